// File: rtl/tick_countdown_timer.sv
// Tick-driven countdown timer with start/pause/resume and optional auto-reload.
// One count per i_TICK strobe; o_DONE pulses for one cycle on the expiring tick.
module tick_countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_TICK,
    input  logic             i_LOAD,
    input  logic [WIDTH-1:0] i_LOAD_VALUE,
    input  logic             i_START,
    input  logic             i_PAUSE,
    input  logic             i_AUTO_RELOAD,
    output logic [WIDTH-1:0] o_COUNT,
    output logic             o_DONE,
    output logic             o_BUSY,
    output logic             o_PAUSED,
    output logic             o_EXPIRED
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [1:0]       state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             done;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state  <= ST_IDLE;
            count  <= ZERO;
            reload <= ZERO;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (i_LOAD) begin
                reload <= i_LOAD_VALUE;
                count  <= i_LOAD_VALUE;
                state  <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_START && count != ZERO)
                            state <= ST_RUN;
                    end
                    ST_RUN: begin
                        // Pause wins over a same-cycle tick; that tick is dropped.
                        if (i_PAUSE) begin
                            state <= ST_PAUSED;
                        end else if (i_TICK) begin
                            if (count > ONE) begin
                                count <= count - ONE;
                            end else if (count == ONE) begin
                                done <= 1'b1;
                                if (i_AUTO_RELOAD) begin
                                    count <= reload;
                                end else begin
                                    count <= ZERO;
                                    state <= ST_EXPIRED;
                                end
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (i_START)
                            state <= ST_RUN;
                    end
                    default: begin
                        if (i_START && reload != ZERO) begin
                            count <= reload;
                            state <= ST_RUN;
                        end
                    end
                endcase
            end
        end
    end

    assign o_COUNT   = count;
    assign o_DONE    = done;
    assign o_BUSY    = (state == ST_RUN);
    assign o_PAUSED  = (state == ST_PAUSED);
    assign o_EXPIRED = (state == ST_EXPIRED);

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed scenarios plus randomized traffic, each cycle compared against a
// behavioural model of the timer's rules.
module tb_tick_countdown_timer;
    localparam int W = 8;

    logic         i_CLK = 1'b0;
    logic         i_RST = 1'b0;
    logic         i_TICK = 1'b0;
    logic         i_LOAD = 1'b0;
    logic [W-1:0] i_LOAD_VALUE = '0;
    logic         i_START = 1'b0;
    logic         i_PAUSE = 1'b0;
    logic         i_AUTO_RELOAD = 1'b0;
    logic [W-1:0] o_COUNT;
    logic         o_DONE, o_BUSY, o_PAUSED, o_EXPIRED;

    int checks = 0;
    int failures = 0;

    // Model: mode is one of "idle", "run", "paused", "expired".
    string m_mode = "idle";
    int    m_cnt = 0;
    int    m_rl = 0;
    bit    m_done = 0;

    tick_countdown_timer #(.WIDTH(W)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_TICK(i_TICK), .i_LOAD(i_LOAD),
        .i_LOAD_VALUE(i_LOAD_VALUE), .i_START(i_START), .i_PAUSE(i_PAUSE),
        .i_AUTO_RELOAD(i_AUTO_RELOAD), .o_COUNT(o_COUNT), .o_DONE(o_DONE),
        .o_BUSY(o_BUSY), .o_PAUSED(o_PAUSED), .o_EXPIRED(o_EXPIRED)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, ld, input int v, input bit st, pa, tk, au);
        m_done = 0;
        if (r) begin
            m_mode = "idle"; m_cnt = 0; m_rl = 0;
        end else if (ld) begin
            m_rl = v; m_cnt = v; m_mode = "idle";
        end else if (m_mode == "idle") begin
            if (st && m_cnt > 0) m_mode = "run";
        end else if (m_mode == "paused") begin
            if (st) m_mode = "run";
        end else if (m_mode == "expired") begin
            if (st && m_rl > 0) begin m_cnt = m_rl; m_mode = "run"; end
        end else if (pa) begin
            m_mode = "paused";
        end else if (tk && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_done = 1;
                if (au) m_cnt = m_rl;
                else m_mode = "expired";
            end
        end
    endtask

    task automatic cyc(input bit r, ld, input int v, input bit st, pa, tk, au);
        i_RST = r; i_LOAD = ld; i_LOAD_VALUE = W'(v); i_START = st;
        i_PAUSE = pa; i_TICK = tk; i_AUTO_RELOAD = au;
        @(posedge i_CLK);
        #1;
        model_step(r, ld, v, st, pa, tk, au);
        chk("count",   int'(o_COUNT),   m_cnt);
        chk("done",    int'(o_DONE),    int'(m_done));
        chk("busy",    int'(o_BUSY),    int'(m_mode == "run"));
        chk("paused",  int'(o_PAUSED),  int'(m_mode == "paused"));
        chk("expired", int'(o_EXPIRED), int'(m_mode == "expired"));
        i_RST = 0; i_LOAD = 0; i_START = 0; i_PAUSE = 0; i_TICK = 0;
    endtask

    task automatic idle_cyc(input int n, input bit au);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, au);
    endtask

    initial begin
        int dones;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Reset mid-run aborts with no done pulse.
        cyc(0, 1, 5, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("rst_count", int'(o_COUNT), 0);
        chk("rst_flags", int'({o_DONE, o_BUSY, o_PAUSED, o_EXPIRED}), 0);

        // One-shot from 5, ticks spaced 3 clocks.
        cyc(0, 1, 5, 0, 0, 0, 0);
        chk("os_load", int'(o_COUNT), 5);
        cyc(0, 0, 0, 1, 0, 0, 0);
        dones = 0;
        for (int i = 1; i <= 5; i++) begin
            idle_cyc(2, 0);
            cyc(0, 0, 0, 0, 0, 1, 0);
            chk("os_seq", int'(o_COUNT), 5 - i);
            dones += int'(o_DONE);
        end
        chk("os_dones", dones, 1);
        chk("os_expired", int'(o_EXPIRED), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        chk("os_hold0", int'(o_COUNT), 0);

        // Auto-reload from 3: done every third tick, never a zero count.
        cyc(0, 1, 3, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 1);
            chk("ar_seq", int'(o_COUNT), (i % 3 == 0) ? 3 : 3 - (i % 3));
            chk("ar_done", int'(o_DONE), int'(i % 3 == 0));
            chk("ar_busy", int'(o_BUSY), 1);
        end

        // Pause holds the count; resume finishes with a single done.
        cyc(0, 1, 4, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            chk("pz_hold", int'(o_COUNT), 2);
            chk("pz_flag", int'(o_PAUSED), 1);
        end
        cyc(0, 0, 0, 1, 0, 0, 0);
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            dones += int'(o_DONE);
        end
        chk("pz_end", int'(o_COUNT), 0);
        chk("pz_dones", dones, 1);

        // Collisions.
        cyc(0, 1, 4, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        chk("col_start_tick", int'(o_COUNT), 4);
        cyc(0, 0, 0, 1, 1, 1, 0);
        chk("col_pause_start", int'(o_PAUSED), 1);
        chk("col_pause_cnt", int'(o_COUNT), 4);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 7, 0, 0, 1, 0);
        chk("col_load_cnt", int'(o_COUNT), 7);
        chk("col_load_flags", int'({o_DONE, o_BUSY, o_PAUSED, o_EXPIRED}), 0);

        // Zero load cannot start; restart from expired reloads.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("zero_idle", int'(o_BUSY), 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("zero_done", int'(o_DONE), 0);
        cyc(0, 1, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("zero_exp", int'(o_EXPIRED), 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("restart_cnt", int'(o_COUNT), 2);
        chk("restart_busy", int'(o_BUSY), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r, ld, st, pa, tk, au;
            int v;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 5) == 0);
            pa = ($urandom_range(0, 11) == 0);
            tk = ($urandom_range(0, 1) == 0);
            au = ($urandom_range(0, 2) != 0);
            v  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
            cyc(r, ld, v, st, pa, tk, au);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
